// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe standard 640x480@60 timing with active-low syncs.
package vga_timing_gen_pkg;

    // Sync polarity codes
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // 640x480@60 horizontal timing, in pixels
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;

    // 640x480@60 vertical timing, in lines
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;

    // Counter/coordinate width and frame counter width
    localparam int DEF_CW  = 10;
    localparam int DEF_FCW = 8;

    // True when val lies in the half-open window [lo, lo+len)
    function automatic logic in_window(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis counter: counts 0..TOTAL-1 on enable and wraps to 0.
// wrap flags the last count so the next axis can be chained off it.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap
);

    logic [CW-1:0] r_count;

    assign wrap  = (r_count == CW'(TOTAL - 1));
    assign count = r_count;

    // Step the count on each enable, returning to 0 after the last position
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Two chained axis counters walk the raster; every pixel tick the current
// (h,v) position is decoded into registered syncs, active-area flag,
// coordinates and line/frame strobes, so outputs trail the counters by one clk.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter logic H_POL    = POL_ACTIVE_LOW,
    parameter logic V_POL    = POL_ACTIVE_LOW,
    parameter int   CW       = DEF_CW,
    parameter int   FCW      = DEF_FCW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_tick,
    output logic           h_sync,
    output logic           v_sync,
    output logic           display_en,
    output logic [CW-1:0]  pixel_x,
    output logic [CW-1:0]  pixel_y,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HA0     = H_SYNC + H_BACK;
    localparam int VA0     = V_SYNC + V_BACK;

    logic [CW-1:0] w_h;
    logic [CW-1:0] w_v;
    logic          w_h_wrap;

    // Horizontal position advances once per pixel tick
    vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .en    (pix_tick),
        .count (w_h),
        .wrap  (w_h_wrap)
    );

    // Vertical position advances on the tick that ends a line
    vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .en    (pix_tick & w_h_wrap),
        .count (w_v),
        .wrap  ()
    );

    logic          w_h_sync_d;
    logic          w_v_sync_d;
    logic          w_de_d;
    logic [CW-1:0] w_px_d;
    logic [CW-1:0] w_py_d;
    logic          w_line_d;
    logic          w_frame_d;

    // Decode the current raster position into next output values
    always_comb begin
        w_h_sync_d = ~H_POL;
        w_v_sync_d = ~V_POL;
        w_de_d     = 1'b0;
        w_px_d     = '0;
        w_py_d     = '0;
        w_line_d   = 1'b0;
        w_frame_d  = 1'b0;

        if (w_h < CW'(H_SYNC)) w_h_sync_d = H_POL;
        if (w_v < CW'(V_SYNC)) w_v_sync_d = V_POL;

        w_de_d = in_window(int'(w_h), HA0, H_ACTIVE) &&
                 in_window(int'(w_v), VA0, V_ACTIVE);
        if (w_de_d) begin
            w_px_d = w_h - CW'(HA0);
            w_py_d = w_v - CW'(VA0);
        end

        w_line_d  = (w_h == '0);
        w_frame_d = w_line_d && (w_v == '0);
    end

    logic           r_h_sync;
    logic           r_v_sync;
    logic           r_display_en;
    logic [CW-1:0]  r_pixel_x;
    logic [CW-1:0]  r_pixel_y;
    logic           r_line_start;
    logic           r_frame_start;
    logic [FCW-1:0] r_frame_count;

    // Load decoded values on a tick; strobes last exactly one clk, rest hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_sync      <= ~H_POL;
            r_v_sync      <= ~V_POL;
            r_display_en  <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_tick) begin
                r_h_sync      <= w_h_sync_d;
                r_v_sync      <= w_v_sync_d;
                r_display_en  <= w_de_d;
                r_pixel_x     <= w_px_d;
                r_pixel_y     <= w_py_d;
                r_line_start  <= w_line_d;
                r_frame_start <= w_frame_d;
                if (w_frame_d) begin
                    r_frame_count <= r_frame_count + FCW'(1);
                end
            end
        end
    end

    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign display_en  = r_display_en;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
